pipe_stage_skid: RTL and testbench

- Elastic pipeline register: one valid/ready stage with a 2-entry skid buffer.
- Sits directly upstream of the fixed-latency delay arrays in the Mips pipeline.
- Absorbs downstream backpressure without a combinational ready path, so the delay line is fed only validated, in-order data.
- Supports stage flush for branch/exception squash.

---
 rtl/pipe_stage_skid.sv | 105 ++++++++++
 tb/tb_pipe_stage_skid.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer, flush and registered in_ready.
// Optional stall counter enabled by defining PIPE_STAGE_SKID_STALL_COUNT_EN.
package pipe_stage_skid_pkg;
  typedef struct packed {
    logic clock;
    logic reset;
  } Util_Control_T;
endpackage

module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  Util_Control_T    ctrl,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_SKID_STALL_COUNT_EN
  ,
  output logic [15:0]      stall_count
`endif
);

  // State bits double as {main_valid, skid_valid}; (0,1) has no encoding.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } state_t;

  logic             clk;
  logic             rst;
  state_t           state;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             main_valid;
  logic             skid_valid;
  logic             in_fire;
  logic             out_fire;

  assign clk        = ctrl.clock;
  assign rst        = ctrl.reset;
  assign main_valid = state[1];
  assign skid_valid = state[0];

  assign in_ready  = !skid_valid && !rst;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      main_data <= RESET_DATA;
      skid_data <= RESET_DATA;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data <= in_data;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_data <= in_data;
          end else if (in_fire) begin
            skid_data <= in_data;
            state     <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data <= skid_data;
            state     <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_STALL_COUNT_EN
  // Saturating count of cycles upstream was refused; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (in_valid && !in_ready && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`endif

  a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst)
    !(skid_valid && !main_valid));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, flush, mid-stream reset, stall count.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int W = 4;

  logic          clk, rst;
  Util_Control_T ctrl;
  logic          flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
`ifdef PIPE_STAGE_SKID_STALL_COUNT_EN
  logic [15:0]   stall_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  assign ctrl.clock = clk;
  assign ctrl.reset = rst;

  pipe_stage_skid #(.WIDTH(W), .RESET_DATA(4'd0)) dut (
    .ctrl       (ctrl),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef PIPE_STAGE_SKID_STALL_COUNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset held two cycles
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming at full rate
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = W'(i); out_ready = 1'b1;
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data",  32'(out_data),  32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Backpressure: 5 main, 6 skid, 7 held upstream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd5;
    tick();
    in_data = 4'd6;
    tick();
    in_data = 4'd7;
    #1;
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_main5",         32'(out_data), 32'd5);
    tick();
    chk("bp_stable5", 32'(out_data), 32'd5);
    chk("bp_valid",   32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_out6",      32'(out_data), 32'd6);
    chk("bp_in_ready1", 32'(in_ready), 32'd1);
    tick();
    chk("bp_out7", 32'(out_data), 32'd7);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Flush while FULL (main=3, skid=4) with out_ready high
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd3;
    tick();
    in_data = 4'd4;
    tick();
    chk("fl_main3", 32'(out_data), 32'd3);
    flush = 1'b1; out_ready = 1'b1; in_data = 4'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready",  32'(in_ready),  32'd1);
    chk("fl_out_data",  32'(out_data),  32'd0);
    tick();
    chk("fl_no_skid", 32'(out_valid), 32'd0);

    // Flush while BUSY discards the in_fire of that cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd2;
    tick();
    flush = 1'b1; in_data = 4'd8;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flb_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("flb_no_capture", 32'(out_valid), 32'd0);

    // Mid-stream reset while BUSY with input offered
    in_valid = 1'b1; in_data = 4'd10;
    tick();
    chk("mr_busy", 32'(out_data), 32'd10);
    rst = 1'b1; in_data = 4'd11;
    #1;
    chk("mr_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data",  32'(out_data),  32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mr_in_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("mr_not_captured", 32'(out_valid), 32'd0);

`ifdef PIPE_STAGE_SKID_STALL_COUNT_EN
    chk("sc_zero", 32'(stall_count), 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd1;
    tick();
    in_data = 4'd2;
    tick();
    repeat (10) tick();
    chk("sc_ten", 32'(stall_count), 32'd10);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sc_flush_keeps", 32'(stall_count), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sc_reset_clears", 32'(stall_count), 32'd0);
    in_valid = 1'b1; in_data = 4'd1;
    tick();
    in_data = 4'd2;
    tick();
    repeat (70000) @(posedge clk);
    #1;
    chk("sc_saturate", 32'(stall_count), 32'd65535);
    in_valid = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
